// File: rtl/apb_slave_bank.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_bank
// Purpose  : APB completer behind an AHB-APB bridge. Holds NUM_SLV one-hot
//            selected register banks of DEPTH 32-bit words, tracks the APB
//            SETUP/ACCESS phases, flags protocol violations (sticky) and
//            counts completed reads and writes.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_bank #(
  parameter int NUM_SLV = 4,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16
) (
  input  logic               Hclk,
  input  logic               Hresetn,
  input  logic [NUM_SLV-1:0] Pselx,
  input  logic               Penable,
  input  logic               Pwrite,
  input  logic [31:0]        Paddr,
  input  logic [31:0]        Pwdata,
  output logic [31:0]        Prdata,
  output logic               prot_err,
  output logic [CNT_W-1:0]   wr_cnt,
  output logic [CNT_W-1:0]   rd_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLV_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [NUM_SLV-1:0] SEL_ONE = NUM_SLV'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // One-hot select to binary slave number (caller guarantees one-hot)
  function automatic logic [SLV_W-1:0] sel_to_idx(input logic [NUM_SLV-1:0] oh);
    logic [SLV_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (oh[i]) r = r | SLV_W'(i);
    end
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [NUM_SLV-1:0]   psel_q, psel_d;
  logic [31:0]          paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic [31:0]          prdata_q, prdata_d;
  logic                 prot_err_q, prot_err_d;
  logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [31:0]          bank_q [NUM_SLV][DEPTH];
  logic [31:0]          bank_d [NUM_SLV][DEPTH];

  logic                 sel;
  logic                 sel_onehot;
  logic                 addr_aligned;
  logic                 setup_ok;
  logic                 same_as_latched;
  logic                 start_setup;
  logic                 commit;
  logic                 err;

  logic [SLV_W-1:0]     in_slv;
  logic [IDX_W-1:0]     in_idx;
  logic [SLV_W-1:0]     lat_slv;
  logic [IDX_W-1:0]     lat_idx;

  // Input qualification shared by the FSM and the datapath
  always_comb begin
    sel             = |Pselx;
    sel_onehot      = sel && ((Pselx & (Pselx - SEL_ONE)) == '0);
    addr_aligned    = (Paddr[1:0] == 2'b00);
    setup_ok        = sel && !Penable && sel_onehot && addr_aligned;
    same_as_latched = (Pselx == psel_q) && (Paddr == paddr_q) &&
                      (Pwrite == pwrite_q) && (Pwdata == pwdata_q);
    in_slv          = sel_to_idx(Pselx);
    in_idx          = Paddr[IDX_W+1:2];
    lat_slv         = sel_to_idx(psel_q);
    lat_idx         = paddr_q[IDX_W+1:2];
  end

  // FSM state register
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: any violation drops back to IDLE and raises err
  always_comb begin
    state_d     = state_q;
    start_setup = 1'b0;
    commit      = 1'b0;
    err         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel) begin
          if (setup_ok) begin
            state_d     = ST_SETUP;
            start_setup = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (sel && Penable && same_as_latched) begin
          state_d = ST_ACCESS;
          commit  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          err     = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!sel) begin
          state_d = ST_IDLE;
        end else if (setup_ok) begin
          state_d     = ST_SETUP;
          start_setup = 1'b1;
        end else begin
          state_d = ST_IDLE;
          err     = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: latch on SETUP entry, read on SETUP entry, write/count on commit
  always_comb begin
    psel_d     = psel_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    prdata_d   = prdata_q;
    prot_err_d = prot_err_q | err;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    bank_d     = bank_q;
    if (start_setup) begin
      psel_d   = Pselx;
      paddr_d  = Paddr;
      pwrite_d = Pwrite;
      pwdata_d = Pwdata;
      // Read data is fetched here so it is stable for the whole ACCESS phase
      if (!Pwrite) prdata_d = bank_q[in_slv][in_idx];
    end
    if (commit) begin
      if (pwrite_q) begin
        bank_d[lat_slv][lat_idx] = pwdata_q;
        wr_cnt_d = wr_cnt_q + CNT_ONE;
      end else begin
        rd_cnt_d = rd_cnt_q + CNT_ONE;
      end
    end
  end

  // Datapath registers; reset clears the banks so a half-done write leaves nothing behind
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      psel_q     <= '0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      prdata_q   <= '0;
      prot_err_q <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      for (int s = 0; s < NUM_SLV; s++) begin
        for (int w = 0; w < DEPTH; w++) begin
          bank_q[s][w] <= '0;
        end
      end
    end else begin
      psel_q     <= psel_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      prdata_q   <= prdata_d;
      prot_err_q <= prot_err_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      bank_q     <= bank_d;
    end
  end

  assign Prdata   = prdata_q;
  assign prot_err = prot_err_q;
  assign wr_cnt   = wr_cnt_q;
  assign rd_cnt   = rd_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_bank
// Purpose  : Self-checking bench for apb_slave_bank. A transaction-level
//            model (word array, counters modulo 2^CNT_W, sticky error flag)
//            predicts every observed value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_bank;

  localparam int NUM_SLV = 4;
  localparam int DEPTH   = 16;
  localparam int CNT_W   = 8;   // narrow counters keep the wrap test short
  localparam int CNT_MOD = 1 << CNT_W;

  logic               Hclk;
  logic               Hresetn;
  logic [NUM_SLV-1:0] Pselx;
  logic               Penable;
  logic               Pwrite;
  logic [31:0]        Paddr;
  logic [31:0]        Pwdata;
  logic [31:0]        Prdata;
  logic               prot_err;
  logic [CNT_W-1:0]   wr_cnt;
  logic [CNT_W-1:0]   rd_cnt;

  apb_slave_bank #(
    .NUM_SLV (NUM_SLV),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .Hclk     (Hclk),
    .Hresetn  (Hresetn),
    .Pselx    (Pselx),
    .Penable  (Penable),
    .Pwrite   (Pwrite),
    .Paddr    (Paddr),
    .Pwdata   (Pwdata),
    .Prdata   (Prdata),
    .prot_err (prot_err),
    .wr_cnt   (wr_cnt),
    .rd_cnt   (rd_cnt)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [31:0] mdl_mem [NUM_SLV][DEPTH];
  logic [31:0] mdl_prdata;
  logic        mdl_err;
  int          mdl_wr;
  int          mdl_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_prot_err"}, {31'd0, prot_err}, {31'd0, mdl_err});
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(mdl_wr));
    check({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(mdl_rd));
    check({tag, "_prdata"}, Prdata, mdl_prdata);
  endtask

  task automatic model_reset();
    for (int s = 0; s < NUM_SLV; s++)
      for (int w = 0; w < DEPTH; w++)
        mdl_mem[s][w] = 32'd0;
    mdl_prdata = 32'd0;
    mdl_err    = 1'b0;
    mdl_wr     = 0;
    mdl_rd     = 0;
  endtask

  function automatic logic [NUM_SLV-1:0] onehot(input int s);
    logic [NUM_SLV-1:0] v;
    v = 1;
    return v << s;
  endfunction

  // Called at a falling edge; returns one falling edge later with the bus idle
  task automatic idle();
    Pselx   = '0;
    Penable = 1'b0;
    @(negedge Hclk);
  endtask

  // Clean two-phase transfer; returns at the falling edge inside ACCESS
  task automatic xfer(input int s, input logic [31:0] addr, input logic wr, input logic [31:0] data);
    int widx;
    Pselx   = onehot(s);
    Paddr   = addr;
    Pwrite  = wr;
    Pwdata  = data;
    Penable = 1'b0;
    @(negedge Hclk);
    Penable = 1'b1;
    @(negedge Hclk);
    widx = int'((addr >> 2) % DEPTH);
    if (wr) begin
      mdl_mem[s][widx] = data;
      mdl_wr = (mdl_wr + 1) % CNT_MOD;
      check("write_keeps_prdata", Prdata, mdl_prdata);
    end else begin
      mdl_prdata = mdl_mem[s][widx];
      mdl_rd = (mdl_rd + 1) % CNT_MOD;
      check("read_data", Prdata, mdl_prdata);
    end
  endtask

  task automatic rd(input int s, input logic [31:0] addr);
    xfer(s, addr, 1'b0, $urandom);
  endtask

  // Protocol-violation injectors: each leaves the bus idle, model changes only prot_err
  task automatic err_enable_no_setup(input logic [NUM_SLV-1:0] sel);
    idle();
    Pselx = sel; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h0; Pwdata = $urandom;
    @(negedge Hclk);
    mdl_err = 1'b1;
    idle();
  endtask

  task automatic err_bad_setup(input logic [NUM_SLV-1:0] sel, input logic [31:0] addr);
    idle();
    Pselx = sel; Penable = 1'b0; Pwrite = 1'b1; Paddr = addr; Pwdata = $urandom;
    @(negedge Hclk);
    mdl_err = 1'b1;
    idle();
  endtask

  task automatic err_addr_change(input int s, input logic [31:0] a1, input logic [31:0] a2,
                                 input logic [31:0] data);
    idle();
    Pselx = onehot(s); Penable = 1'b0; Pwrite = 1'b1; Paddr = a1; Pwdata = data;
    @(negedge Hclk);
    Penable = 1'b1; Paddr = a2;
    @(negedge Hclk);
    mdl_err = 1'b1;
    idle();
  endtask

  task automatic err_no_enable(input int s, input logic [31:0] addr, input logic [31:0] data);
    idle();
    Pselx = onehot(s); Penable = 1'b0; Pwrite = 1'b1; Paddr = addr; Pwdata = data;
    @(negedge Hclk);
    @(negedge Hclk);
    mdl_err = 1'b1;
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;
    logic [31:0] addr;

    Hresetn = 1'b0;
    Pselx = '0; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
    model_reset();
    repeat (3) @(negedge Hclk);
    Hresetn = 1'b1;
    @(negedge Hclk);

    // Reset state
    check("reset_prdata", Prdata, 32'd0);
    check("reset_prot_err", {31'd0, prot_err}, 32'd0);
    check("reset_wr_cnt", 32'(wr_cnt), 32'd0);
    check("reset_rd_cnt", 32'(rd_cnt), 32'd0);

    // Write then read back on slave 1, word 2
    xfer(1, 32'h8, 1'b1, 32'hDEADBEEF);
    idle();
    rd(1, 32'h8);
    check("t1_prdata", Prdata, 32'hDEADBEEF);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t1_rd_cnt", 32'(rd_cnt), 32'd1);
    check("t1_prot_err", {31'd0, prot_err}, 32'd0);
    idle();

    // Back-to-back write/read with no idle in between; other slave untouched
    xfer(0, 32'hC, 1'b1, 32'h11);
    rd(0, 32'hC);
    check("t2_b2b_prdata", Prdata, 32'h11);
    rd(2, 32'hC);
    check("t2_other_slave", Prdata, 32'h0);
    idle();

    // Aliasing above the word index
    xfer(3, 32'h40, 1'b1, 32'hA5);
    idle();
    rd(3, 32'h0);
    check("t5_alias", Prdata, 32'hA5);
    idle();
    check_status("directed");

    // Randomized clean traffic, mixing idle gaps and back-to-back transfers
    for (int i = 0; i < 300; i++) begin
      s    = $urandom_range(0, NUM_SLV - 1);
      addr = $urandom & 32'hFFFF_FFFC;
      xfer(s, addr, 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 2) == 0) idle();
      if ((i % 50) == 49) check_status("random");
    end
    idle();
    check_status("random_end");

    // Drive the write counter around to exactly zero
    n = CNT_MOD - mdl_wr;
    for (int i = 0; i < n; i++) begin
      xfer($urandom_range(0, NUM_SLV - 1), $urandom & 32'hFFFF_FFFC, 1'b1, $urandom);
    end
    idle();
    check("wr_cnt_wrap", 32'(wr_cnt), 32'd0);
    check_status("wrap");

    // Full readback via aliased addresses
    for (int sl = 0; sl < NUM_SLV; sl++)
      for (int w = 0; w < DEPTH; w++)
        rd(sl, 32'(w * 4 + $urandom_range(0, 7) * DEPTH * 4));
    idle();

    // Protocol violations
    err_enable_no_setup(4'b0011);
    check("t3_prot_err", {31'd0, prot_err}, 32'd1);
    check_status("t3");
    repeat (3) idle();
    check("t3_sticky", {31'd0, prot_err}, 32'd1);

    err_addr_change(2, 32'h4, 32'h8, 32'hCAFE_0001);
    check_status("t4");
    rd(2, 32'h4);
    rd(2, 32'h8);
    idle();

    err_bad_setup(4'b1010, 32'h10);
    err_bad_setup(onehot(1), 32'h21);
    err_bad_setup(onehot(0), 32'h32);
    err_no_enable(3, 32'h1C, 32'hBAD0_BAD0);
    check_status("errs");
    rd(1, 32'h20);
    rd(0, 32'h30);
    rd(3, 32'h1C);
    for (int i = 0; i < 8; i++) begin
      s = $urandom_range(0, NUM_SLV - 1);
      addr = ($urandom & 32'hFFFF_FFFC);
      case ($urandom_range(0, 3))
        0: err_bad_setup(onehot(s) | onehot((s + 1) % NUM_SLV), addr);
        1: err_bad_setup(onehot(s), addr | 32'(1 + $urandom_range(0, 2)));
        2: err_addr_change(s, addr, addr + 32'h4, $urandom);
        default: err_no_enable(s, addr, $urandom);
      endcase
      rd(s, addr);
      rd(s, addr + 32'h4);
      idle();
    end
    check_status("rand_errs");

    // Reset between SETUP and ACCESS of a write
    idle();
    Pselx = onehot(3); Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h14; Pwdata = 32'h55;
    @(negedge Hclk);
    Hresetn = 1'b0;
    Pselx = '0;
    #1;
    model_reset();
    check("t6_async_prdata", Prdata, 32'd0);
    check("t6_async_prot_err", {31'd0, prot_err}, 32'd0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    @(negedge Hclk);
    check_status("t6_after_reset");
    rd(3, 32'h14);
    check("t6_word_zero", Prdata, 32'd0);
    idle();
    xfer(3, 32'h14, 1'b1, 32'h55);
    rd(3, 32'h14);
    check("t6_clean_xfer", Prdata, 32'h55);
    idle();
    check_status("t6_final");
    rd(1, 32'h8);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
